// File: rtl/stopwatch_bus_master_if.sv
// Host command/response channels plus the single-cycle stopwatch register strobe bus.
// The master modport is the bus-master block's view; slave is the host/stopwatch side.
interface stopwatch_bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        sw_rwenable;
    logic        sw_rw;
    logic [31:0] sw_addr;
    logic [31:0] sw_wdata;
    logic [31:0] sw_rdata;

    modport master (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready, sw_rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output sw_rwenable, sw_rw, sw_addr, sw_wdata
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready, sw_rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  sw_rwenable, sw_rw, sw_addr, sw_wdata
    );
endinterface

// File: rtl/stopwatch_bus_master.sv
// Turns host valid/ready commands into one-cycle stopwatch register strobes and
// returns read data or a decode error; also gates the stopwatch count strobe.
module stopwatch_bus_master #(
    parameter int N_MEM      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    stopwatch_bus_master_if.master        bus,
    input  logic                          count_en,
    output logic                          sw_count,
    output logic                          count_lost
);
    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, RESP, GAP} state_t;

    localparam logic [31:0] MEM_END  = 32'(6 + N_MEM);
    localparam logic [3:0]  GAP_LOAD = 4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    state_t      state, state_nxt;
    logic        live;
    logic        legal;
    logic        take;
    logic [3:0]  gap_cnt;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        sw_rw_q;
    logic [31:0] sw_addr_q;
    logic [31:0] sw_wdata_q;

    // addr 1 is read-only; 2..5 and the memory window 6..5+N_MEM are read/write.
    always_comb begin
        legal = 1'b0;
        if (bus.cmd_addr == 32'd1)
            legal = bus.cmd_rw;
        else if (bus.cmd_addr >= 32'd2 && bus.cmd_addr < MEM_END)
            legal = 1'b1;
    end

    // live keeps every output low during reset and the first cycle after release.
    assign take = live && (state == IDLE) && bus.cmd_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        bus.cmd_ready   = 1'b0;
        bus.rsp_valid   = 1'b0;
        bus.sw_rwenable = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = live;
                if (live && bus.cmd_valid) state_nxt = legal ? ISSUE : RESP;
            end
            ISSUE: begin
                bus.sw_rwenable = 1'b1;
                state_nxt       = sw_rw_q ? CAPTURE : RESP;
            end
            CAPTURE: state_nxt = RESP;
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: if (gap_cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live       <= 1'b0;
            gap_cnt    <= 4'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
            sw_rw_q    <= 1'b0;
            sw_addr_q  <= 32'd0;
            sw_wdata_q <= 32'd0;
            count_lost <= 1'b0;
        end else begin
            live       <= 1'b1;
            count_lost <= count_en && (state == ISSUE);
            if (take) begin
                rdata_q <= 32'd0;
                err_q   <= !legal;
                // Rejected commands never touch the bus, so the strobe fields keep their old values.
                if (legal) begin
                    sw_rw_q    <= bus.cmd_rw;
                    sw_addr_q  <= bus.cmd_addr;
                    sw_wdata_q <= bus.cmd_wdata;
                end
            end
            if (state == CAPTURE) rdata_q <= bus.sw_rdata;
            if (state == RESP && bus.rsp_ready && GAP_CYCLES > 0)
                gap_cnt <= GAP_LOAD;
            else if (state == GAP && gap_cnt != 4'd0)
                gap_cnt <= gap_cnt - 4'd1;
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.sw_rw     = sw_rw_q;
    assign bus.sw_addr   = sw_addr_q;
    assign bus.sw_wdata  = sw_wdata_q;
    assign sw_count      = live && count_en && !bus.sw_rwenable;
endmodule

// File: tb/tb_stopwatch_bus_master.sv
// Directed bench: u0 (no gap) talks to a small stopwatch register model, u1 (gap of 3)
// answers every read with a constant.
module tb_stopwatch_bus_master;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic count_en = 1'b0;
    logic count_en1 = 1'b0;
    logic sw_count0, count_lost0, sw_count1, count_lost1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    stopwatch_bus_master_if b0();
    stopwatch_bus_master_if b1();

    stopwatch_bus_master #(.N_MEM(8), .GAP_CYCLES(0)) u0 (
        .clk(clk), .reset_n(reset_n), .bus(b0.master),
        .count_en(count_en), .sw_count(sw_count0), .count_lost(count_lost0));

    stopwatch_bus_master #(.N_MEM(8), .GAP_CYCLES(3)) u1 (
        .clk(clk), .reset_n(reset_n), .bus(b1.master),
        .count_en(count_en1), .sw_count(sw_count1), .count_lost(count_lost1));

    // Stopwatch model: addr1 is a counter stepping by reg4 (reset 10) per sw_count.
    logic [31:0] sreg [0:15];
    logic [31:0] scnt, srd;
    assign b0.sw_rdata = srd;
    assign b1.sw_rdata = 32'h55;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) sreg[i] <= 32'd0;
            sreg[4] <= 32'd10;
            scnt    <= 32'd0;
            srd     <= 32'd0;
        end else begin
            if (b0.sw_rwenable && b0.sw_rw)
                srd <= (b0.sw_addr == 32'd1) ? scnt : sreg[b0.sw_addr[3:0]];
            else if (b0.sw_rwenable && b0.sw_addr < 32'd16)
                sreg[b0.sw_addr[3:0]] <= b0.sw_wdata;
            if (sw_count0) scnt <= scnt + sreg[4];
        end
    end

    int issue_cycles = 0, lost_pulses = 0, cnt_in_issue = 0, run = 0, max_run = 0;
    logic [31:0] last_waddr = 32'd0, last_wdata = 32'd0;

    always @(negedge clk) begin
        if (b0.sw_rwenable) begin
            issue_cycles++;
            run++;
            if (run > max_run) max_run = run;
            if (sw_count0) cnt_in_issue++;
            if (!b0.sw_rw) begin
                last_waddr = b0.sw_addr;
                last_wdata = b0.sw_wdata;
            end
        end else begin
            run = 0;
        end
        if (count_lost0) lost_pulses++;
    end

    // lat: clocks from accept edge to rsp_valid; wt: cycles cmd_ready was low before accept.
    task automatic do_cmd(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat, output int wt);
        b0.cmd_valid = 1'b1; b0.cmd_rw = rw; b0.cmd_addr = addr; b0.cmd_wdata = wd;
        b0.rsp_ready = 1'b1;
        wt = 0; lat = 0;
        @(negedge clk);
        while (!b0.cmd_ready && wt < 50) begin wt++; @(negedge clk); end
        @(posedge clk); #1;
        b0.cmd_valid = 1'b0;
        do begin @(negedge clk); lat++; end while (!b0.rsp_valid && lat < 50);
        rd = b0.rsp_rdata;
        er = b0.rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        count_en = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({b0.cmd_ready, b0.rsp_valid, b0.rsp_err, b0.sw_rwenable, b0.sw_rw, sw_count0, count_lost0} !== 7'd0) begin
            failures++; $display("FAIL reset_ctrl got %b want 0", {b0.cmd_ready, b0.rsp_valid, b0.rsp_err, b0.sw_rwenable, b0.sw_rw, sw_count0, count_lost0});
        end
        checks++;
        if ({b0.rsp_rdata, b0.sw_addr, b0.sw_wdata} !== 96'd0) begin
            failures++; $display("FAIL reset_data got %h want 0", {b0.rsp_rdata, b0.sw_addr, b0.sw_wdata});
        end
        count_en = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_rw();
        logic [31:0] rd; logic er; int lat, wt;
        do_cmd(1'b0, 32'd3, 32'd20, rd, er, lat, wt);
        checks++;
        if (er !== 1'b0 || lat != 2) begin failures++; $display("FAIL write3 err=%b lat=%0d want 0/2", er, lat); end
        do_cmd(1'b0, 32'd4, 32'd5, rd, er, lat, wt);
        do_cmd(1'b1, 32'd3, 32'd0, rd, er, lat, wt);
        checks++;
        if (rd !== 32'd20 || er !== 1'b0 || lat != 3) begin
            failures++; $display("FAIL read3 got %0d err=%b lat=%0d want 20/0/3", rd, er, lat);
        end
        do_cmd(1'b0, 32'd5, 32'hFFFF_FFFF, rd, er, lat, wt);
        checks++;
        if (last_waddr !== 32'd5 || last_wdata !== 32'hFFFF_FFFF || er !== 1'b0) begin
            failures++; $display("FAIL csr_write got a=%h d=%h err=%b want 5/ffffffff/0", last_waddr, last_wdata, er);
        end
        checks++;
        if (max_run != 1) begin failures++; $display("FAIL issue_len got %0d want 1", max_run); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat, wt, ic;
        logic [31:0] bad [0:3];
        bad[0] = 32'd0; bad[1] = 32'd14; bad[2] = 32'd15; bad[3] = 32'h100;
        ic = issue_cycles;
        do_cmd(1'b1, 32'd3, 32'd0, rd, er, lat, wt);
        do_cmd(1'b0, 32'd1, 32'd7, rd, er, lat, wt);
        checks++;
        if (er !== 1'b1 || lat != 1 || rd !== 32'd0) begin
            failures++; $display("FAIL write_ro err=%b lat=%0d rd=%h want 1/1/0", er, lat, rd);
        end
        ic = ic + 1;
        for (int i = 0; i < 4; i++) begin
            do_cmd(1'b1, bad[i], 32'd0, rd, er, lat, wt);
            checks++;
            if (er !== 1'b1 || lat != 1) begin
                failures++; $display("FAIL bad_addr %h err=%b lat=%0d want 1/1", bad[i], er, lat);
            end
        end
        checks++;
        if (issue_cycles != ic) begin failures++; $display("FAIL err_no_strobe got %0d want %0d", issue_cycles, ic); end
        do_cmd(1'b1, 32'd1, 32'd0, rd, er, lat, wt);
        checks++;
        if (er !== 1'b0 || lat != 3) begin failures++; $display("FAIL read_ro err=%b lat=%0d want 0/3", er, lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat, wt;
        for (int i = 0; i < 8; i++) begin
            do_cmd(1'b0, 32'(6 + i), 32'(8'hA0 + i), rd, er, lat, wt);
            checks++;
            if (er !== 1'b0 || wt != 0) begin failures++; $display("FAIL mem_wr %0d err=%b wait=%0d want 0/0", i, er, wt); end
        end
        for (int i = 0; i < 8; i++) begin
            do_cmd(1'b1, 32'(6 + i), 32'd0, rd, er, lat, wt);
            checks++;
            if (rd !== 32'(8'hA0 + i) || er !== 1'b0 || wt != 0 || lat != 3) begin
                failures++; $display("FAIL mem_rd %0d got %h err=%b wait=%0d lat=%0d want %h/0/0/3", i, rd, er, wt, lat, 32'(8'hA0 + i));
            end
        end
    endtask

    task automatic test_count();
        logic [31:0] rd [0:3]; logic er; int lat, wt, lp, ci;
        lp = lost_pulses; ci = cnt_in_issue;
        count_en = 1'b1;
        for (int i = 0; i < 4; i++) do_cmd(1'b1, 32'd1, 32'd0, rd[i], er, lat, wt);
        count_en = 1'b0;
        // 4-cycle command period with the ISSUE cycle suppressed: 3 counts of stride 5.
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd[i+1] - rd[i] !== 32'd15) begin
                failures++; $display("FAIL count_step %0d got %0d want 15", i, rd[i+1] - rd[i]);
            end
        end
        checks++;
        if (lost_pulses - lp != 4) begin failures++; $display("FAIL count_lost got %0d want 4", lost_pulses - lp); end
        checks++;
        if (cnt_in_issue != ci) begin failures++; $display("FAIL count_in_issue got %0d want %0d", cnt_in_issue, ci); end
    endtask

    task automatic test_backpressure();
        int n; logic stable;
        b0.cmd_valid = 1'b1; b0.cmd_rw = 1'b1; b0.cmd_addr = 32'd3; b0.rsp_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!b0.cmd_ready && n < 50) begin n++; @(negedge clk); end
        @(posedge clk); #1;
        b0.cmd_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!b0.rsp_valid && n < 50);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(b0.rsp_valid === 1'b1 && b0.rsp_rdata === 32'd20 && b0.cmd_ready === 1'b0)) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1 || n != 3) begin failures++; $display("FAIL hold_rsp stable=%b lat=%0d want 1/3", stable, n); end
        b0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (b0.cmd_ready !== 1'b1 || b0.rsp_valid !== 1'b0) begin
            failures++; $display("FAIL release_rsp ready=%b valid=%b want 1/0", b0.cmd_ready, b0.rsp_valid);
        end
        // Gap instance: handshake, then three idle cycles before cmd_ready returns.
        b1.cmd_valid = 1'b1; b1.cmd_rw = 1'b1; b1.cmd_addr = 32'd2; b1.rsp_ready = 1'b1;
        n = 0;
        while (!b1.cmd_ready && n < 50) begin n++; @(negedge clk); end
        @(posedge clk); #1;
        b1.cmd_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!b1.rsp_valid && n < 50);
        checks++;
        if (b1.rsp_rdata !== 32'h55 || n != 3) begin failures++; $display("FAIL gap_read got %h lat=%0d want 55/3", b1.rsp_rdata, n); end
        @(posedge clk); #1;
        n = 0;
        do begin @(negedge clk); n++; end while (!b1.cmd_ready && n < 50);
        checks++;
        if (n != 4) begin failures++; $display("FAIL gap_ready got %0d want 4", n); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat, wt, n; logic seen;
        b0.cmd_valid = 1'b1; b0.cmd_rw = 1'b1; b0.cmd_addr = 32'd3; b0.rsp_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!b0.cmd_ready && n < 50) begin n++; @(negedge clk); end
        @(posedge clk); #1;
        b0.cmd_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({b0.cmd_ready, b0.rsp_valid, b0.rsp_err, b0.sw_rwenable, b0.sw_rw, sw_count0, count_lost0} !== 7'd0 ||
            {b0.rsp_rdata, b0.sw_addr, b0.sw_wdata} !== 96'd0) begin
            failures++; $display("FAIL abort_outputs addr=%h rw=%b valid=%b want 0", b0.sw_addr, b0.sw_rw, b0.rsp_valid);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin @(negedge clk); if (b0.rsp_valid !== 1'b0) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_rsp got %b want 0", seen); end
        do_cmd(1'b1, 32'd4, 32'd0, rd, er, lat, wt);
        checks++;
        if (rd !== 32'd10 || er !== 1'b0) begin failures++; $display("FAIL post_reset_rd4 got %0d err=%b want 10/0", rd, er); end
    endtask

    initial begin
        b0.cmd_valid = 1'b0; b0.cmd_rw = 1'b0; b0.cmd_addr = 32'd0; b0.cmd_wdata = 32'd0; b0.rsp_ready = 1'b0;
        b1.cmd_valid = 1'b0; b1.cmd_rw = 1'b0; b1.cmd_addr = 32'd0; b1.cmd_wdata = 32'd0; b1.rsp_ready = 1'b0;
        test_reset();
        test_basic_rw();
        test_errors();
        test_back_to_back();
        test_count();
        test_backpressure();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
